// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encodings and a constant-evaluable ceiling-log2 for the bit counter width.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..v-1 (at least 1).
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder cell; the per-bit arithmetic element of serial_addsub.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock.
// Subtraction is a + ~b + 1: B is inverted at load and the carry is preset to 1.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last;
    logic             accept;

    assign accept = (state == S_IDLE) && start;
    assign last   = (cnt == CW'(WIDTH - 1));

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: RUN lasts exactly WIDTH edges, DONE exactly one.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last)  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs decode directly from the state flops.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Operand load on accept, then shift one bit per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            result <= {fa_sum, result[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
            // cout has its own flop so the carry preset of a new operation
            // does not disturb the held result.
            if (last) cout <= fa_cout;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      ovf <= 1'b0;
        else if (state == S_RUN && last) ovf <= carry ^ fa_cout;
    end
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8). An arithmetic/timing
// model tracks what the outputs must be; directed vectors add literal checks.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) edge_n <= edge_n + 1;

    // ---------------- behavioural model ----------------
    bit           m_act;
    int           m_cyc;
    logic [W-1:0] m_res, p_res;
    logic         m_cout, p_cout;
    logic         m_ovf, p_ovf;

    task automatic compute(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                           output logic [W-1:0] r, output logic c, output logic o);
        longint unsigned full;
        longint sa, sb, s;
        full = longint'(ai) + (si ? (longint'(~bi) & ((64'd1 << W) - 1)) : longint'(bi)) + longint'(si);
        r = full[W-1:0];
        c = full[W];
        sa = longint'($signed(ai));
        sb = longint'($signed(bi));
        s  = si ? sa - sb : sa + sb;
        o  = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 0; m_cyc <= 0;
            m_res <= '0; m_cout <= 0; m_ovf <= 0;
        end else if (!m_act) begin
            if (start) begin
                logic [W-1:0] r; logic c, o;
                compute(a, b, sub, r, c, o);
                p_res <= r; p_cout <= c; p_ovf <= o;
                m_act <= 1; m_cyc <= 0;
            end
        end else if (m_cyc == W) begin
            m_act <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == W) begin
                m_res <= p_res; m_cout <= p_cout; m_ovf <= p_ovf;
            end
        end
    end

    // Compare DUT with model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("busy", busy, m_act);
        chk("done", done, m_act && m_cyc == W);
        if (!m_act || m_cyc == 0 || m_cyc == W) begin
            chk("result_model", result, m_res);
            chk("cout_model", cout, m_cout);
`ifdef SERIAL_ADDSUB_OVF_EN
            chk("ovf_model", ovf, m_ovf);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic op(input string nm, input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                      input logic [W-1:0] er, input logic ec, input logic eo);
        int got;
        got = 0;
        @(negedge clk);
        a = ai; b = bi; sub = si; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= W + 5; i++) begin
            @(posedge clk); #1;
            if (done) begin got = i; break; end
        end
        chk({nm, "_done_offset"}, got, W);
        chk({nm, "_result"}, result, er);
        chk({nm, "_cout"}, cout, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk({nm, "_ovf"}, ovf, eo);
`else
        if (eo === 1'bx) $display("note: bad vector %s", nm);
`endif
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int ndone;
        int d[3];
        int k;
        int busy_lo;

        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_cout", cout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op("sub_05_03", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);
        op("sub_03_05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
        op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start pulsed during RUN must be ignored
        @(negedge clk);
        a = 8'h21; b = 8'h12; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= W + 6; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (i == 3) begin start = 1'b1; a = 8'h33; b = 8'h44; sub = 1'b1; end
            if (i == 4) start = 1'b0;
        end
        chk("ignore_done_count", ndone, 1);
        chk("ignore_result", result, 8'h33);
        chk("ignore_cout", cout, 0);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 8'hAA; b = 8'h55; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_cout", cout, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("midrst_ovf", ovf, 0);
`endif
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        op("after_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        // start held high: back-to-back operations
        @(negedge clk);
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        k = 0; busy_lo = 0;
        for (int i = 0; i < 3 * (W + 2) + 4 && k < 3; i++) begin
            @(posedge clk); #1;
            if (done) begin d[k] = edge_n; k++; end
            else if (k >= 1 && !busy) busy_lo++;
        end
        start = 1'b0;
        chk("b2b_done_count", k, 3);
        if (k == 3) begin
            chk("b2b_spacing_1", d[1] - d[0], W + 2);
            chk("b2b_spacing_2", d[2] - d[1], W + 2);
        end
        chk("b2b_busy_low", busy_lo, 2);
        chk("b2b_result", result, 8'h30);
        repeat (W + 4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
